life_sequencer: RTL and testbench

Generation controller for the 8×8 Game-of-Life core. It owns the registered 64-bit grid and feeds it to the combinational `datapath` next-generation logic. It commits `grid_evolve` back into the grid either at a programmable rate (run) or one generation at a time (step), and loads initial patterns from the switch seed or the `lfsr` output. It also counts generations and halts automatically on extinction or still life.

---
 rtl/life_pkg.sv | 13 +
 rtl/gen_divider.sv | 28 ++
 rtl/life_sequencer.sv | 134 +++++++++++++
 tb/tb_life_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the 8x8 Game-of-Life core: grid size and the
// generation controller's state encoding.
package life_pkg;

  localparam int GRID_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/gen_divider.sv
// Generation-rate divider: counts 0..tick_div and flags the terminal count.
// A counter beyond a freshly lowered tick_div simply wraps through all-ones.
module gen_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] tick_div,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_reg;

  assign tc = (cnt_reg == tick_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tc ? '0 : cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Generation controller: owns the grid register, commits the datapath's next
// generation on step or at the divided run rate, and halts on extinction/still life.
module life_sequencer #(
  parameter int GRID_W = life_pkg::GRID_W,
  parameter int DIV_W  = 24,
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  tick_div,
  input  logic              run,
  input  logic              step,
  input  logic              load,
  input  logic              load_src,
  input  logic [GRID_W-1:0] seed,
  input  logic [GRID_W-1:0] rnd,
  input  logic [GRID_W-1:0] grid_evolve,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic              gen_tick,
  output logic              running,
  output logic              stable,
  output logic              extinct
);

  import life_pkg::*;

  state_t             state_reg, state_next;
  logic [GRID_W-1:0]  grid_reg;
  logic [GEN_W-1:0]   gen_count_reg;
  logic               gen_tick_reg;
  logic               running_reg;
  logic               stable_reg;
  logic               extinct_reg;

  logic               commit;
  logic               div_clear;
  logic               div_en;
  logic               div_tc;
  logic               evolve_empty;
  logic               evolve_same;

  assign evolve_empty = (grid_evolve == '0);
  assign evolve_same  = (grid_evolve == grid_reg);

  gen_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .clear    (div_clear),
    .en       (div_en),
    .tick_div (tick_div),
    .tc       (div_tc)
  );

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    div_clear  = 1'b0;
    div_en     = 1'b0;

    if (load) begin
      state_next = run ? RUN : IDLE;
      div_clear  = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (step) begin
            commit = 1'b1;
          end else if (run) begin
            state_next = RUN;
            div_clear  = 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state_next = IDLE;
            div_clear  = 1'b1;
          end else begin
            div_en = 1'b1;
            commit = div_tc;
          end
        end
        default: ;  // HALT: only load leaves
      endcase
    end

    // A commit that empties or freezes the grid overrides the state chosen above.
    if (commit && (evolve_empty || evolve_same)) begin
      state_next = HALT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      grid_reg      <= '0;
      gen_count_reg <= '0;
      gen_tick_reg  <= 1'b0;
      running_reg   <= 1'b0;
      stable_reg    <= 1'b0;
      extinct_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      running_reg  <= (state_next == RUN);
      gen_tick_reg <= commit;
      if (load) begin
        grid_reg      <= load_src ? rnd : seed;
        gen_count_reg <= '0;
        stable_reg    <= 1'b0;
        extinct_reg   <= 1'b0;
      end else if (commit) begin
        grid_reg <= grid_evolve;
        if (gen_count_reg != '1) begin
          gen_count_reg <= gen_count_reg + GEN_W'(1);
        end
        if (evolve_empty) begin
          extinct_reg <= 1'b1;
        end else if (evolve_same) begin
          stable_reg <= 1'b1;
        end
      end
    end
  end

  assign grid      = grid_reg;
  assign gen_count = gen_count_reg;
  assign gen_tick  = gen_tick_reg;
  assign running   = running_reg;
  assign stable    = stable_reg;
  assign extinct   = extinct_reg;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a behavioural Life model standing in
// for the datapath; a second instance with a 4-bit counter covers saturation.
module tb_life_sequencer;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0018_1800;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0000_0001;
  localparam logic [63:0] RND_VAL = 64'hDEAD_BEEF_0123_4567;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] tick_div;
  logic        run, step, load, load_src;
  logic [63:0] seed, rnd;

  logic [63:0] grid, evolve;
  logic [15:0] gen_count;
  logic        gen_tick, running, stable, extinct;

  logic [63:0] grid4, evolve4;
  logic [3:0]  gen_count4;
  logic        gen_tick4, running4, stable4, extinct4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Non-wrapping 8x8 Life, bit 0 = top-left, row-major.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8) begin
              cnt += int'(g[(r + dr) * 8 + c + dc]);
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign evolve  = life_next(grid);
  assign evolve4 = life_next(grid4);

  life_sequencer dut (
    .clk(clk), .reset(reset), .tick_div(tick_div), .run(run), .step(step),
    .load(load), .load_src(load_src), .seed(seed), .rnd(rnd),
    .grid_evolve(evolve), .grid(grid), .gen_count(gen_count),
    .gen_tick(gen_tick), .running(running), .stable(stable), .extinct(extinct)
  );

  life_sequencer #(.GEN_W(4)) dut4 (
    .clk(clk), .reset(reset), .tick_div(tick_div), .run(run), .step(step),
    .load(load), .load_src(load_src), .seed(seed), .rnd(rnd),
    .grid_evolve(evolve4), .grid(grid4), .gen_count(gen_count4),
    .gen_tick(gen_tick4), .running(running4), .stable(stable4), .extinct(extinct4)
  );

  typedef struct {
    logic        load;
    logic        src;
    logic        step;
    logic        run;
    logic [63:0] seed;
    logic [63:0] rnd;
    logic [63:0] e_grid;
    logic [15:0] e_gen;
    logic        e_tick;
    logic        e_run;
    logic        e_stable;
    logic        e_ext;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic s, input logic st, input logic r,
                       input logic [63:0] sd, input logic [63:0] rn);
    load = l; load_src = s; step = st; run = r; seed = sd; rnd = rn;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, BLINK_H, 64'h0, BLINK_H, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, BLINK_V, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, BLINK_H, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, BLINK_V, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, BLINK_V, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, BLOCK,   64'h0, BLOCK,   16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, BLOCK,   16'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, BLOCK,   16'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, BLOCK,   16'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, SINGLE,  64'h0, SINGLE,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0,   16'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, BLOCK, RND_VAL, RND_VAL, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; tick_div = 24'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    chk("rst_grid", grid, 64'h0);
    chk("rst_gen", 64'(gen_count), 64'h0);
    chk("rst_flags", {60'h0, gen_tick, running, stable, extinct}, 64'h0);
    reset = 1'b0;
    tick();

    // Single-cycle vectors: load, step, halt on still life / extinction, load-vs-step.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].load, vecs[i].src, vecs[i].step, vecs[i].run, vecs[i].seed, vecs[i].rnd);
      tick();
      $display("vec %0d: grid=%h gen=%0d tick=%b run=%b stable=%b extinct=%b",
               i, grid, gen_count, gen_tick, running, stable, extinct);
      chk($sformatf("v%0d_grid", i), grid, vecs[i].e_grid);
      chk($sformatf("v%0d_gen", i), 64'(gen_count), 64'(vecs[i].e_gen));
      chk($sformatf("v%0d_tick", i), 64'(gen_tick), 64'(vecs[i].e_tick));
      chk($sformatf("v%0d_running", i), 64'(running), 64'(vecs[i].e_run));
      chk($sformatf("v%0d_stable", i), 64'(stable), 64'(vecs[i].e_stable));
      chk($sformatf("v%0d_extinct", i), 64'(extinct), 64'(vecs[i].e_ext));
    end

    // Run at tick_div = 4: commits on the 5th and 10th edge after entry.
    drive(1'b1, 1'b0, 1'b0, 1'b0, BLINK_H, 64'h0);
    tick();
    tick_div = 24'd4;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
    tick();
    chk("run_enter", 64'(running), 64'h1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      $display("run cyc %0d: grid=%h gen=%0d tick=%b", i, grid, gen_count, gen_tick);
      chk($sformatf("run%0d_grid", i), grid, (i < 5 || i == 10) ? BLINK_H : BLINK_V);
      chk($sformatf("run%0d_tick", i), 64'(gen_tick), 64'((i == 5 || i == 10) ? 1 : 0));
      chk($sformatf("run%0d_gen", i), 64'(gen_count), 64'((i < 5) ? 0 : (i < 10) ? 1 : 2));
    end
    tick(); tick();
    run = 1'b0;
    tick();
    chk("drop_running", 64'(running), 64'h0);
    for (int i = 0; i < 6; i++) tick();
    $display("after drop: grid=%h gen=%0d", grid, gen_count);
    chk("drop_grid", grid, BLINK_H);
    chk("drop_gen", 64'(gen_count), 64'd2);

    // Saturation: tick_div = 0, load straight into RUN, commit every cycle.
    tick_div = 24'd0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, BLINK_H, 64'h0);
    tick();
    load = 1'b0;
    chk("sat_running", 64'(running4), 64'h1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      $display("sat cyc %0d: gen4=%0d gen16=%0d grid4=%h", i, gen_count4, gen_count, grid4);
      chk($sformatf("sat%0d_gen4", i), 64'(gen_count4), 64'((i > 15) ? 15 : i));
      chk($sformatf("sat%0d_gen16", i), 64'(gen_count), 64'(i));
      chk($sformatf("sat%0d_grid4", i), grid4, (i % 2 == 1) ? BLINK_V : BLINK_H);
      chk($sformatf("sat%0d_tick4", i), 64'(gen_tick4), 64'h1);
    end

    // Asynchronous reset mid-RUN: outputs clear well before the next edge.
    #2 reset = 1'b1;
    #1;
    $display("async reset: grid=%h gen=%0d running=%b", grid, gen_count, running);
    chk("areset_grid", grid, 64'h0);
    chk("areset_gen", 64'(gen_count), 64'h0);
    chk("areset_flags", {60'h0, gen_tick, running, stable, extinct}, 64'h0);
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
